dsp_post_stage: RTL
===================

Name: dsp_post_stage

Overview:
- Back end of the DSP48A1 slice. Consumes the front-stage outputs: the multiplier product, the D:A:B concatenation and the registered C bus.
- Registers the product (M), selects the X/Z post-adder operands, and performs add/subtract with carry-in.
- Drives the P register, the PCOUT cascade and the CARRYOUT/CARRYOUTF outputs.
- Accumulation runs through P feedback.

Parameters:
- MREG, 1, 1 = product registered, 0 = bypass.
- CARRYINREG, 1, 1 = selected carry-in registered, 0 = bypass.
- PREG, 1, 1 = P and CARRYOUT registered, 0 = bypass.
- OPMODEREG, 1, 1 = OPMODE[7,5,3:0] registered, 0 = bypass.
- CARRYINSEL, "OPMODE5", carry-in source: "OPMODE5" or "CARRYIN".

Ports:
- clk  in  1  single clock; all registers on the rising edge.
- RSTN  in  1  asynchronous active-low reset for every register in the block.
- CEM  in  1  clock enable, M register.
- CECARRYIN  in  1  clock enable, carry-in register.
- CEOPMODE  in  1  clock enable, OPMODE register.
- CEP  in  1  clock enable, P and CARRYOUT registers.
- OPMODE  in  8  bits [1:0] X select, [3:2] Z select, [5] carry-in, [7] post add/sub; bits 4 and 6 ignored.
- mult_in  in  36  product from the front stage.
- concatenated  in  48  {D[11:0],A[17:0],B[17:0]} from the front stage.
- C  in  48  registered C from the front stage.
- PCIN  in  48  cascade input from the slice below.
- CARRYIN  in  1  external carry-in.
- M  out  36  buffered product.
- P  out  48  result.
- PCOUT  out  48  cascade output, always equal to P.
- CARRYOUT  out  1  post-adder carry/borrow.
- CARRYOUTF  out  1  copy of CARRYOUT for fabric use.

Behaviour:
- Reset: RSTN low clears M, carry-in, OPMODE, P and CARRYOUT registers to 0 immediately, without waiting for a clock.
  - Outputs read 0 on the registered paths.
  - Bypassed paths stay combinational.
  - On deassertion, the first update happens at the next rising edge where CE is high.
- Register semantics: each register loads only when its CE is high. When the matching *REG parameter is 0, the register is a wire.
- X mux, on OPMODE[1:0]:
  - 0: 48'b0
  - 1: {12'b0, M}
  - 2: P
  - 3: concatenated
- Z mux, on OPMODE[3:2]:
  - 0: 48'b0
  - 1: PCIN
  - 2: P
  - 3: C
- Carry-in: cin = OPMODE[5] or CARRYIN, chosen by CARRYINSEL. Passes through the CARRYINREG stage.
- Post-adder, computed at 49 bits:
  - OPMODE[7]=0: {1'b0,Z} + {1'b0,X} + cin
  - OPMODE[7]=1: {1'b0,Z} - ({1'b0,X} + cin)
  - P = result[47:0]; CARRYOUT = result[48], which is the borrow in subtract mode.
  - No saturation. The result wraps modulo 2^48.
- Latency with defaults: mult_in to P is 2 cycles (MREG + PREG). C, concatenated or PCIN to P is 1 cycle. OPMODE changes take effect 1 cycle later than data when OPMODEREG=1.
- Accumulation: Z=P with X=M adds M into P on every CEP cycle. With CEP low, P holds and PCOUT holds.
- Illegal configuration: PREG=0 with X=2 or Z=2 forms a combinational loop. This must never occur; a simulation assertion fires on it.
- Simultaneous events: RSTN low overrides every CE. A CE held low during reset has no effect.

Optional Feature:
- Macro: DSP_POST_OVERFLOW_EN.
- With the macro defined, an extra output port OVF (1 bit) is present. It is a sticky signed-overflow flag:
  - Set on a P load whose result overflows, i.e. operands of the effective add share a sign that differs from result[47].
  - Cleared on a P load with Z != 2, the start of a new accumulation. When clear and set coincide, OVF takes the overflow of the current load.
  - Reset to 0 by RSTN.
  - Registered with P regardless of PREG.
- Without the macro, there is no OVF port and no logic.

Decomposition:
- Package dsp_post_pkg holds:
  - X-select encodings: X_ZERO=0, X_M=1, X_P=2, X_DAB=3.
  - Z-select encodings: Z_ZERO=0, Z_PCIN=1, Z_P=2, Z_C=3.
  - OPMODE bit-index constants.
  - Width constants: P_W=48, M_W=36.
- One sub-module, dsp_reg_async: parameterised-width register with async active-low reset, CE and a bypass parameter. It is instantiated for M, carry-in, OPMODE, P and CARRYOUT.

Test Plan:
- Reset mid-accumulate: P=48'd12, pull RSTN low between clock edges -> P, PCOUT, M and CARRYOUT read 0 before the next edge; the first result is 2 cycles after RSTN rises.
- Multiply-add: mult_in=36'd6, C=48'd10, OPMODE=8'h0D (Z=C, X=M) -> P=48'd16 two cycles after mult_in is applied; CARRYOUT=0.
- Subtract with borrow: OPMODE=8'h8D, C=5, mult_in=7 -> P=48'hFFFF_FFFF_FFFE, CARRYOUT=1.
- Accumulate: P cleared, then OPMODE=8'h09 (Z=P, X=M) with mult_in=3 held -> P=3,6,9,12 on successive cycles; drop CEP for 2 cycles -> P stays 12.
- Carry-in: CARRYINSEL="OPMODE5", OPMODE=8'h23, concatenated=48'hFFFF_FFFF_FFFF, Z=0 -> P=0, CARRYOUT=1, CARRYOUTF=1.
- With DSP_POST_OVERFLOW_EN: C=48'h7FFF_FFFF_FFFF, X=M=1, Z=C -> OVF=1; then accumulate Z=P -> OVF stays 1; load with Z=C and no overflow -> OVF=0.

Source files
------------

// File: rtl/dsp_post_pkg.sv
// dsp_post_pkg: shared constants for the DSP48A1-style post-adder stage.
//   - X/Z operand-select encodings (OPMODE[1:0] and OPMODE[3:2])
//   - OPMODE bit positions, datapath widths
//   - signed-overflow helper used by the optional OVF flag
package dsp_post_pkg;

  localparam int P_W = 48;
  localparam int M_W = 36;

  // OPMODE bit positions
  localparam int OP_X_LSB = 0;
  localparam int OP_Z_LSB = 2;
  localparam int OP_CIN   = 5;
  localparam int OP_SUB   = 7;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } z_sel_e;

  // Two operands of like sign producing a result of the other sign.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/dsp_post_checker.sv
// dsp_post_checker: simulation checks for dsp_post_stage.
//   Flags the combinational loop formed when P is unregistered and fed back
//   through the X or Z mux.
//   Ports: i_xsel[1:0], i_zsel[1:0] (effective operand selects)
module dsp_post_checker
  import dsp_post_pkg::*;
#(
  parameter int PREG = 1
) (
  input logic [1:0] i_xsel,
  input logic [1:0] i_zsel
);

  if (PREG == 0) begin : g_loop_chk
    // P feedback with an unregistered P is a zero-delay loop.
    always_comb begin
      assert ((i_xsel != X_P) && (i_zsel != Z_P))
        else $error("dsp_post_stage: P feedback selected with PREG=0");
    end
  end else begin : g_no_chk
    logic w_unused_sel;
    assign w_unused_sel = &{1'b0, i_xsel, i_zsel};
  end

endmodule

// File: rtl/dsp_reg_async.sv
// dsp_reg_async: optional pipeline register with async active-low reset and CE.
//   Parameters: W (width), REG (1 = register, 0 = combinational pass-through)
//   Ports: i_clk, i_rst_n (async, active low), i_ce, i_d[W-1:0], o_q[W-1:0]
module dsp_reg_async #(
  parameter int W   = 1,
  parameter int REG = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_ce,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  if (REG == 1) begin : g_reg
    logic [W-1:0] r_q;

    // Capture on CE; reset clears without waiting for a clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_q <= '0;
      end else if (i_ce) begin
        r_q <= i_d;
      end else begin
        r_q <= r_q;
      end
    end

    assign o_q = r_q;
  end else begin : g_bypass
    logic w_unused_ctrl;
    assign w_unused_ctrl = &{1'b0, i_clk, i_rst_n, i_ce};
    assign o_q = i_d;
  end

endmodule

// File: rtl/dsp_post_stage.sv
// dsp_post_stage: back end of a DSP48A1 slice.
//   M register, X/Z operand muxes, 48-bit post add/subtract with carry-in,
//   P register with PCOUT cascade and CARRYOUT/CARRYOUTF.
//   Inputs : clk, RSTN (async active low), CEM, CECARRYIN, CEOPMODE, CEP,
//            OPMODE[7:0], mult_in[35:0], concatenated[47:0], C[47:0],
//            PCIN[47:0], CARRYIN
//   Outputs: M[35:0], P[47:0], PCOUT[47:0], CARRYOUT, CARRYOUTF,
//            OVF (only when DSP_POST_OVERFLOW_EN is defined: sticky signed
//            overflow, cleared by any P load that does not accumulate on P)
module dsp_post_stage
  import dsp_post_pkg::*;
#(
  parameter int MREG       = 1,
  parameter int CARRYINREG = 1,
  parameter int PREG       = 1,
  parameter int OPMODEREG  = 1,
  parameter     CARRYINSEL = "OPMODE5"
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic             CEM,
  input  logic             CECARRYIN,
  input  logic             CEOPMODE,
  input  logic             CEP,
  input  logic [7:0]       OPMODE,
  input  logic [M_W-1:0]   mult_in,
  input  logic [P_W-1:0]   concatenated,
  input  logic [P_W-1:0]   C,
  input  logic [P_W-1:0]   PCIN,
  input  logic             CARRYIN,
  output logic [M_W-1:0]   M,
  output logic [P_W-1:0]   P,
  output logic [P_W-1:0]   PCOUT,
  output logic             CARRYOUT,
  output logic             CARRYOUTF
`ifdef DSP_POST_OVERFLOW_EN
  ,
  output logic             OVF
`endif
);

  logic [7:0]     w_op_raw;
  logic [7:0]     w_op;
  logic [M_W-1:0] w_m;
  logic           w_cin_raw;
  logic           w_cin;
  logic [P_W-1:0] w_x;
  logic [P_W-1:0] w_z;
  logic [P_W:0]   w_x_cin;
  logic [P_W:0]   w_sum;
  logic [P_W-1:0] w_p;
  logic           w_co;
  x_sel_e         w_xsel;
  z_sel_e         w_zsel;

  // Bits 4 and 6 are unused by the datapath; hold them at zero.
  assign w_op_raw = {OPMODE[OP_SUB], 1'b0, OPMODE[OP_CIN], 1'b0, OPMODE[3:0]};

  dsp_reg_async #(.W(8), .REG(OPMODEREG)) u_op_reg (
    .i_clk(clk), .i_rst_n(RSTN), .i_ce(CEOPMODE), .i_d(w_op_raw), .o_q(w_op)
  );

  dsp_reg_async #(.W(M_W), .REG(MREG)) u_m_reg (
    .i_clk(clk), .i_rst_n(RSTN), .i_ce(CEM), .i_d(mult_in), .o_q(w_m)
  );

  // Carry-in is taken from the raw OPMODE so it stays aligned with the OPMODE register.
  if (CARRYINSEL == "CARRYIN") begin : g_cin_ext
    assign w_cin_raw = CARRYIN;
  end else begin : g_cin_op
    logic w_unused_carryin;
    assign w_unused_carryin = CARRYIN;
    assign w_cin_raw        = OPMODE[OP_CIN];
  end

  dsp_reg_async #(.W(1), .REG(CARRYINREG)) u_cin_reg (
    .i_clk(clk), .i_rst_n(RSTN), .i_ce(CECARRYIN), .i_d(w_cin_raw), .o_q(w_cin)
  );

  assign w_xsel = x_sel_e'(w_op[OP_X_LSB +: 2]);
  assign w_zsel = z_sel_e'(w_op[OP_Z_LSB +: 2]);

  // X operand select.
  always_comb begin
    w_x = '0;
    case (w_xsel)
      X_ZERO:  w_x = '0;
      X_M:     w_x = {12'd0, w_m};
      X_P:     w_x = P;
      X_DAB:   w_x = concatenated;
      default: w_x = '0;
    endcase
  end

  // Z operand select.
  always_comb begin
    w_z = '0;
    case (w_zsel)
      Z_ZERO:  w_z = '0;
      Z_PCIN:  w_z = PCIN;
      Z_P:     w_z = P;
      Z_C:     w_z = C;
      default: w_z = '0;
    endcase
  end

  // 49-bit post-adder; bit 48 is carry on add and borrow on subtract.
  always_comb begin
    w_x_cin = {1'b0, w_x} + {48'd0, w_cin};
    if (w_op[OP_SUB]) begin
      w_sum = {1'b0, w_z} - w_x_cin;
    end else begin
      w_sum = {1'b0, w_z} + w_x_cin;
    end
  end

  dsp_reg_async #(.W(P_W), .REG(PREG)) u_p_reg (
    .i_clk(clk), .i_rst_n(RSTN), .i_ce(CEP), .i_d(w_sum[P_W-1:0]), .o_q(w_p)
  );

  dsp_reg_async #(.W(1), .REG(PREG)) u_co_reg (
    .i_clk(clk), .i_rst_n(RSTN), .i_ce(CEP), .i_d(w_sum[P_W]), .o_q(w_co)
  );

  assign M         = w_m;
  assign P         = w_p;
  assign PCOUT     = w_p;
  assign CARRYOUT  = w_co;
  assign CARRYOUTF = w_co;

`ifdef DSP_POST_OVERFLOW_EN
  logic w_ovf_now;
  logic w_ovf_next;
  logic r_ovf;

  // Overflow of this load; a load that does not feed back P starts a new run.
  always_comb begin
    w_ovf_now = add_ovf(w_z[P_W-1],
                        w_op[OP_SUB] ? ~w_x[P_W-1] : w_x[P_W-1],
                        w_sum[P_W-1]);
    if (w_zsel == Z_P) begin
      w_ovf_next = r_ovf | w_ovf_now;
    end else begin
      w_ovf_next = w_ovf_now;
    end
  end

  // Sticky flag, always registered alongside P loads.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_ovf <= 1'b0;
    end else if (CEP) begin
      r_ovf <= w_ovf_next;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign OVF = r_ovf;
`endif

  dsp_post_checker #(.PREG(PREG)) u_chk (
    .i_xsel(w_xsel), .i_zsel(w_zsel)
  );

endmodule
